// File: rtl/noc_pkg.sv
// Shared address layout, TX sequencer state encoding and counter widths for
// the GPU network interface.
package noc_pkg;
  localparam int ADDR_W     = 6;
  localparam int GROUP_MSB  = 5;
  localparam int GROUP_LSB  = 2;
  localparam int LOCAL_MSB  = 1;
  localparam int LOCAL_LSB  = 0;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    LOOP = 2'd3
  } tx_state_t;

  function automatic logic [ADDR_W-1:0] make_addr(input logic [3:0] group_id,
                                                  input logic [1:0] local_id);
    logic [ADDR_W-1:0] addr;
    addr = '0;
    addr[GROUP_MSB:GROUP_LSB] = group_id;
    addr[LOCAL_MSB:LOCAL_LSB] = local_id;
    return addr;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; an extra wrap bit on each pointer
// separates full from empty. A push while full is taken only alongside a pop.
module sync_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg[AW-1:0]];
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
endmodule

// File: rtl/gpu_noc_interface.sv
// GPU-side network interface: paced injection into the leaf router (which has
// no ready), local loopback of self-addressed flits, and a dropping RX FIFO.
module gpu_noc_interface
  import noc_pkg::*;
#(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] GROUP_ID   = 4'b0111,
  parameter logic [1:0] LOCAL_ID   = 2'd2,
  parameter int         INJECT_GAP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DWIDTH-1:0]     core_tx_data,
  input  logic [ADDR_W-1:0]     core_tx_dest,
  input  logic                  core_tx_valid,
  output logic                  core_tx_ready,
  output logic [DWIDTH-1:0]     core_rx_data,
  output logic                  core_rx_valid,
  input  logic                  core_rx_ready,
  output logic [DWIDTH-1:0]     net_out_data,
  output logic                  net_out_valid,
  output logic [ADDR_W-1:0]     net_out_dest,
  input  logic [DWIDTH-1:0]     net_in_data,
  input  logic                  net_in_valid,
  input  logic                  net_busy,
  output logic                  tx_fifo_full,
  output logic                  tx_fifo_empty,
  output logic                  rx_fifo_full,
  output logic                  rx_fifo_empty,
  output logic [DROP_CNT_W-1:0] rx_drop_count,
  output logic [1:0]            tx_state
);
  localparam logic [ADDR_W-1:0] SELF_ADDR = make_addr(GROUP_ID, LOCAL_ID);
  localparam int TXW      = DWIDTH + ADDR_W;
  localparam int GAP_W    = $clog2(INJECT_GAP + 1) + 1;
  localparam int GAP_LAST = (INJECT_GAP > 0) ? INJECT_GAP - 1 : 0;

  tx_state_t            state_reg, state_next;
  logic [GAP_W-1:0]     gap_reg, gap_next;
  logic                 net_out_valid_reg;
  logic [DWIDTH-1:0]    net_out_data_reg;
  logic [ADDR_W-1:0]    net_out_dest_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  logic [TXW-1:0]    tx_head;
  logic [ADDR_W-1:0] head_dest;
  logic [DWIDTH-1:0] head_data;
  logic              tx_push, tx_pop, load;
  logic              core_pop, net_push, loop_push, rx_push, drop;
  logic [DWIDTH-1:0] rx_push_data;

  assign core_tx_ready = reset & ~tx_fifo_full;
  assign tx_push       = core_tx_valid & core_tx_ready;
  assign head_dest     = tx_head[TXW-1:DWIDTH];
  assign head_data     = tx_head[DWIDTH-1:0];

  sync_fifo #(.WIDTH(TXW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data ({core_tx_dest, core_tx_data}),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_fifo_full),
    .empty     (tx_fifo_empty)
  );

  // Network flits win the RX write port; loopback waits rather than drops.
  assign core_rx_valid = ~rx_fifo_empty;
  assign core_pop      = core_rx_valid & core_rx_ready;
  assign net_push      = net_in_valid & (~rx_fifo_full | core_pop);
  assign loop_push     = (state_reg == LOOP) & ~rx_fifo_full & ~net_in_valid;
  assign rx_push       = net_push | loop_push;
  assign rx_push_data  = net_in_valid ? net_in_data : head_data;
  assign drop          = net_in_valid & rx_fifo_full & ~core_pop;

  sync_fifo #(.WIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (core_pop),
    .pop_data  (core_rx_data),
    .full      (rx_fifo_full),
    .empty     (rx_fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    tx_pop     = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!tx_fifo_empty && !net_busy) begin
          if (head_dest == SELF_ADDR) begin
            state_next = LOOP;
          end else begin
            tx_pop     = 1'b1;
            load       = 1'b1;
            state_next = SEND;
          end
        end
      end
      SEND: begin
        gap_next   = '0;
        state_next = (INJECT_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_reg == GAP_W'(GAP_LAST)) state_next = IDLE;
        else                             gap_next   = gap_reg + 1'b1;
      end
      LOOP: begin
        if (loop_push) begin
          tx_pop     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      gap_reg           <= '0;
      net_out_valid_reg <= 1'b0;
      net_out_data_reg  <= '0;
      net_out_dest_reg  <= '0;
      drop_cnt_reg      <= '0;
    end else begin
      state_reg         <= state_next;
      gap_reg           <= gap_next;
      net_out_valid_reg <= load;
      if (load) begin
        net_out_data_reg <= head_data;
        net_out_dest_reg <= head_dest;
      end
      if (drop && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign net_out_valid = net_out_valid_reg;
  assign net_out_data  = net_out_data_reg;
  assign net_out_dest  = net_out_dest_reg;
  assign rx_drop_count = drop_cnt_reg;
  assign tx_state      = state_reg;
endmodule

// File: tb/tb_gpu_noc_interface.sv
// Self-checking bench: directed scenarios plus randomized TX/RX traffic checked
// against queue-based models of injection order, loopback order and RX capacity.
module tb_gpu_noc_interface;
  localparam int DWIDTH     = 16;
  localparam int DEPTH      = 8;
  localparam int INJECT_GAP = 1;
  localparam logic [5:0] SELF = 6'b0111_10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] core_tx_data = '0;
  logic [5:0]  core_tx_dest = '0;
  logic        core_tx_valid = 1'b0;
  logic        core_tx_ready;
  logic [15:0] core_rx_data;
  logic        core_rx_valid;
  logic        core_rx_ready = 1'b0;
  logic [15:0] net_out_data;
  logic        net_out_valid;
  logic [5:0]  net_out_dest;
  logic [15:0] net_in_data = '0;
  logic        net_in_valid = 1'b0;
  logic        net_busy = 1'b0;
  logic        tx_fifo_full, tx_fifo_empty, rx_fifo_full, rx_fifo_empty;
  logic [7:0]  rx_drop_count;
  logic [1:0]  tx_state;

  gpu_noc_interface #(
    .DWIDTH(DWIDTH), .FIFO_DEPTH(DEPTH), .GROUP_ID(4'b0111),
    .LOCAL_ID(2'd2), .INJECT_GAP(INJECT_GAP)
  ) dut (
    .clk(clk), .reset(reset),
    .core_tx_data(core_tx_data), .core_tx_dest(core_tx_dest),
    .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .core_rx_data(core_rx_data), .core_rx_valid(core_rx_valid),
    .core_rx_ready(core_rx_ready),
    .net_out_data(net_out_data), .net_out_valid(net_out_valid),
    .net_out_dest(net_out_dest),
    .net_in_data(net_in_data), .net_in_valid(net_in_valid), .net_busy(net_busy),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
    .rx_drop_count(rx_drop_count), .tx_state(tx_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_pulse = -1;
  int tx_pulses  = 0;
  bit tight = 1'b0;
  bit busy_prev = 1'b0;
  bit loop_mon_on = 1'b0;
  bit rx_model_on = 1'b0;
  bit last_accepted = 1'b0;
  int drop_m = 0;
  logic [21:0] tx_exp[$];
  logic [15:0] loop_exp[$];
  logic [15:0] rxq[$];
  logic [21:0] exp_flit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Network-side monitor: every injected flit must be the oldest outstanding one.
  always @(negedge clk) begin
    if (reset && net_out_valid) begin
      check("tx_busy_respected", busy_prev, 1'b0);
      check("tx_queue_nonempty", tx_exp.size() != 0, 1'b1);
      if (tx_exp.size() != 0) begin
        exp_flit = tx_exp.pop_front();
        check("tx_dest", net_out_dest, exp_flit[21:16]);
        check("tx_data", net_out_data, exp_flit[15:0]);
      end
      if (last_pulse >= 0) begin
        if (tight) check("tx_spacing", cyc - last_pulse, INJECT_GAP + 2);
        else       check("tx_spacing_min", (cyc - last_pulse) >= INJECT_GAP + 2, 1'b1);
      end
      $display("tx flit cycle=%0d dest=%h data=%h", cyc, net_out_dest, net_out_data);
      last_pulse = cyc;
      tx_pulses++;
    end
    busy_prev = net_busy;
  end

  function automatic logic [5:0] rand_dest(input bit allow_self);
    logic [5:0] d;
    d = 6'($urandom);
    while (!allow_self && d == SELF) d = 6'($urandom);
    return d;
  endfunction

  // One clock: sample pre-edge handshakes into the models, then step past the edge.
  task automatic cycle();
    int  sz;
    bit  pop;
    @(negedge clk);
    last_accepted = reset && core_tx_valid && core_tx_ready;
    if (last_accepted) begin
      if (core_tx_dest == SELF) begin
        if (loop_mon_on) loop_exp.push_back(core_tx_data);
      end else begin
        tx_exp.push_back({core_tx_dest, core_tx_data});
      end
    end
    if (loop_mon_on && core_rx_valid && core_rx_ready) begin
      check("loop_queue_nonempty", loop_exp.size() != 0, 1'b1);
      if (loop_exp.size() != 0) check("loop_data", core_rx_data, loop_exp.pop_front());
    end
    if (rx_model_on) begin
      sz = rxq.size();
      check("rx_valid", core_rx_valid, sz != 0);
      if (sz != 0) check("rx_data", core_rx_data, rxq[0]);
      check("rx_full", rx_fifo_full, sz == DEPTH);
      check("rx_drops", rx_drop_count, drop_m);
      pop = core_rx_ready && sz != 0;
      if (pop) void'(rxq.pop_front());
      if (net_in_valid) begin
        if (sz < DEPTH || pop) rxq.push_back(net_in_data);
        else if (drop_m < 255) drop_m++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    core_tx_valid = 1'b0; core_rx_ready = 1'b0; net_in_valid = 1'b0; net_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tx_exp.delete(); loop_exp.delete(); rxq.delete();
    drop_m = 0; last_pulse = -1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int p0;
    logic [15:0] exp5[4];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_net_valid", net_out_valid, 1'b0);
    check("rst_net_data", net_out_data, 16'h0);
    check("rst_net_dest", net_out_dest, 6'h0);
    check("rst_drops", rx_drop_count, 8'h0);
    check("rst_state", tx_state, 2'd0);
    check("rst_tx_ready", core_tx_ready, 1'b0);
    check("rst_empties", {tx_fifo_empty, rx_fifo_empty}, 2'b11);
    check("rst_fulls", {tx_fifo_full, rx_fifo_full}, 2'b00);
    reset = 1'b1;
    #1;
    check("rel_tx_ready", core_tx_ready, 1'b1);

    // 1: single send and its exact timing
    core_tx_valid = 1'b1; core_tx_dest = 6'b0100_01; core_tx_data = 16'hA5A5;
    cycle();
    core_tx_valid = 1'b0;
    check("t1_no_early_valid", net_out_valid, 1'b0);
    cycle();
    check("t1_valid", net_out_valid, 1'b1);
    check("t1_dest", net_out_dest, 6'h11);
    check("t1_data", net_out_data, 16'hA5A5);
    check("t1_state_send", tx_state, 2'd1);
    cycle();
    check("t1_valid_one_cycle", net_out_valid, 1'b0);
    check("t1_state_gap", tx_state, 2'd2);
    check("t1_data_hold", net_out_data, 16'hA5A5);
    check("t1_dest_hold", net_out_dest, 6'h11);
    cycle();
    check("t1_state_idle", tx_state, 2'd0);

    // 2: backpressure through net_busy, then paced drain in order
    repeat (3) cycle();
    last_pulse = -1; tight = 1'b1; p0 = tx_pulses;
    net_busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      core_tx_valid = 1'b1; core_tx_data = 16'(i); core_tx_dest = rand_dest(1'b0);
      check("t2_ready_before_full", core_tx_ready, 1'b1);
      cycle();
    end
    core_tx_data = 16'd9; core_tx_dest = rand_dest(1'b0);
    check("t2_full", tx_fifo_full, 1'b1);
    check("t2_ready_low", core_tx_ready, 1'b0);
    repeat (3) cycle();
    check("t2_no_inject_busy", tx_pulses - p0, 0);
    net_busy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (last_accepted) break;
    end
    core_tx_valid = 1'b0;
    check("t2_flit9_accepted", last_accepted, 1'b1);
    for (int k = 0; k < 60 && (tx_pulses - p0) < 9; k++) cycle();
    check("t2_pulse_count", tx_pulses - p0, 9);
    tight = 1'b0;
    repeat (4) cycle();

    // 3: loopback never reaches the network
    p0 = tx_pulses;
    core_tx_valid = 1'b1; core_tx_dest = SELF; core_tx_data = 16'hBEEF;
    cycle();
    core_tx_valid = 1'b0;
    cycle();
    check("t3_state_loop", tx_state, 2'd3);
    check("t3_rx_not_yet", core_rx_valid, 1'b0);
    cycle();
    check("t3_rx_valid", core_rx_valid, 1'b1);
    check("t3_rx_data", core_rx_data, 16'hBEEF);
    check("t3_state_idle", tx_state, 2'd0);
    core_rx_ready = 1'b1;
    cycle();
    core_rx_ready = 1'b0;
    check("t3_rx_drained", rx_fifo_empty, 1'b1);
    check("t3_no_net", tx_pulses - p0, 0);

    // 5: network flits pre-empt a waiting loopback
    d = 16'($urandom);
    core_tx_valid = 1'b1; core_tx_dest = SELF; core_tx_data = d;
    cycle();
    core_tx_valid = 1'b0;
    cycle();
    check("t5_state_loop", tx_state, 2'd3);
    for (int j = 0; j < 3; j++) begin
      net_in_valid = 1'b1; net_in_data = 16'hC000 + 16'(j);
      cycle();
      check("t5_state_hold", tx_state, 2'd3);
    end
    net_in_valid = 1'b0;
    cycle();
    check("t5_state_idle", tx_state, 2'd0);
    exp5[0] = 16'hC000; exp5[1] = 16'hC001; exp5[2] = 16'hC002; exp5[3] = d;
    core_rx_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("t5_rx_valid", core_rx_valid, 1'b1);
      check("t5_rx_order", core_rx_data, exp5[j]);
      cycle();
    end
    core_rx_ready = 1'b0;
    check("t5_rx_empty", rx_fifo_empty, 1'b1);

    // 4: RX overflow, then random RX traffic, then drop-count saturation
    apply_reset();
    rx_model_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      net_in_valid = 1'b1; net_in_data = 16'h0100 + 16'(i);
      cycle();
    end
    net_in_valid = 1'b0;
    check("t4_full", rx_fifo_full, 1'b1);
    check("t4_drops", rx_drop_count, 8'd2);
    core_rx_ready = 1'b1;
    repeat (9) cycle();
    check("t4_drained", rx_fifo_empty, 1'b1);
    for (int i = 0; i < 300; i++) begin
      net_in_valid = ($urandom_range(0, 9) < 7);
      net_in_data = 16'($urandom);
      core_rx_ready = ($urandom_range(0, 9) < 4);
      cycle();
    end
    core_rx_ready = 1'b0; net_in_valid = 1'b1;
    for (int i = 0; i < 270; i++) begin
      net_in_data = 16'($urandom);
      cycle();
    end
    net_in_valid = 1'b0;
    check("t4_drop_saturated", rx_drop_count, 8'd255);
    core_rx_ready = 1'b1;
    repeat (10) cycle();
    core_rx_ready = 1'b0;
    rx_model_on = 1'b0;

    // Random TX traffic mixing network and self-addressed flits
    apply_reset();
    loop_mon_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      core_tx_valid = $urandom_range(0, 1);
      core_tx_dest = ($urandom_range(0, 7) == 0) ? SELF : rand_dest(1'b0);
      core_tx_data = 16'($urandom);
      net_busy = ($urandom_range(0, 2) == 0);
      core_rx_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end
    core_tx_valid = 1'b0; net_busy = 1'b0; core_rx_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (tx_exp.size() == 0 && loop_exp.size() == 0 && tx_fifo_empty && tx_state == 2'd0) break;
      cycle();
    end
    check("rand_tx_all_sent", tx_exp.size(), 0);
    check("rand_loop_all_seen", loop_exp.size(), 0);
    check("rand_tx_empty", tx_fifo_empty, 1'b1);
    loop_mon_on = 1'b0;
    core_rx_ready = 1'b0;
    repeat (4) cycle();

    // 6: reset while a flit is on the wire with more queued
    net_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      core_tx_valid = 1'b1; core_tx_dest = rand_dest(1'b0); core_tx_data = 16'($urandom);
      cycle();
    end
    core_tx_valid = 1'b0; net_busy = 1'b0;
    for (int k = 0; k < 10 && !net_out_valid; k++) cycle();
    check("t6_in_send", tx_state, 2'd1);
    reset = 1'b0;
    #1;
    tx_exp.delete();
    check("t6_valid_dropped", net_out_valid, 1'b0);
    check("t6_state_idle", tx_state, 2'd0);
    check("t6_tx_empty", tx_fifo_empty, 1'b1);
    check("t6_ready_forced", core_tx_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    last_pulse = -1;
    cycle();
    check("t6_ready_after", core_tx_ready, 1'b1);
    check("t6_tx_empty_after", tx_fifo_empty, 1'b1);
    check("t6_state_after", tx_state, 2'd0);
    check("t6_drops_after", rx_drop_count, 8'd0);
    repeat (5) cycle();
    check("t6_no_stale_send", net_out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
